mem_stage: RTL
==============

# mem_stage

Memory stage of the five-stage RISC-V pipeline, directly downstream of the execute stage. Owns the EX/MEM pipeline register, drives the data-memory bus through a valid/ack handshake, performs store byte-lane steering and load alignment/sign-extension, and stalls the pipeline while an access is outstanding. Feeds the writeback stage and returns `ALUResultM` to the execute-stage forwarding mux (`ForwardAE`/`ForwardBE` = 2'b10).

## Interface
Parameters: none.

Ports:
- `clk` in 1: single pipeline clock.
- `reset` in 1: asynchronous, active-high.
- `RegWriteE`, `MemWriteE` in 1 each: execute-stage controls.
- `ResultSrcE` in 3: result select; 3'b001 marks a load.
- `StoreSrcE` in 2: 00 word, 01 half, 10 byte.
- `LoadSrcE` in 3: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
- `ALUResultE`, `WriteDataE`, `PCPlus4E` in 32 each: address/result, store data, link value.
- `RdE` in 5: destination register.
- `DataAck` in 1: memory completes the access this cycle.
- `DataRData` in 32: read word, valid when `DataAck`=1.
- `DataReq` out 1: access request.
- `DataWE` out 1: 1 store, 0 load.
- `DataAddr` out 32: word-aligned address, i.e. `{ALUResultM[31:2],2'b00}`.
- `DataBE` out 4: byte enables.
- `DataWData` out 32: lane-steered store data.
- `RegWriteM` out 1, `ResultSrcM` out 3, `RdM` out 5, `ALUResultM` out 32, `PCPlus4M` out 32: to writeback and hazard unit.
- `ReadDataM` out 32: aligned, extended load data.
- `StallM` out 1: to hazard unit; stalls F/D/E and holds this stage.
- `MisalignM` out 1: misaligned-access indication.

## Operation
- EX/MEM register loads all `*E` inputs on `clk` rising edge when `StallM`=0; it holds when `StallM`=1.
- Memory op in M: `MemM` = `MemWriteM` | (`ResultSrcM`==3'b001).
- Misaligned: word with `ALUResultM[1:0]`≠0, or half with `ALUResultM[0]`≠0. No request is issued. `MisalignM`=1 for that cycle. The store is dropped. `RegWriteM` is forced to 0 for the load. `ReadDataM`=0. No stall.
- FSM states and transitions:
  - IDLE: `DataReq` = `MemM` & aligned. On `DataAck`, go to DONE; otherwise, if the request was issued, go to WAIT.
  - WAIT: `DataReq`=1 with address, BE, WE and data held stable. On `DataAck`, go to DONE.
  - DONE: `DataReq`=0, then IDLE.
- `StallM` = 1 in IDLE when a request is issued, and in WAIT; 0 in DONE and otherwise. Every aligned memory op therefore occupies M for at least 2 cycles.
- On `DataAck` for a load, aligned/extended data is captured into a 32-bit read buffer. `ReadDataM` outputs that buffer in DONE and holds it until the next load ack.
- Store steering:
  - word: BE 1111, data unchanged.
  - half: BE 0011<<(2·`addr[1]`), data {2{wd[15:0]}}.
  - byte: BE 0001<<`addr[1:0]`, data {4{wd[7:0]}}.
- Load alignment:
  - Select the byte `DataRData[8·a+7:8·a]` or the half `DataRData[16·a1+15:16·a1]`.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes through.
- `DataAck` in DONE or in IDLE with no request is ignored.

## Timing
- Reset (async, immediate): FSM IDLE. All EX/MEM register fields are 0, which forms a bubble: `RegWriteM`=0, `ResultSrcM`=0, `MemWriteM`=0, `RdM`=0, `ALUResultM`=0, `PCPlus4M`=0. Read buffer 0. `DataReq`=0, `DataWE`=0, `DataBE`=0, `DataAddr`=0, `DataWData`=0, `StallM`=0, `MisalignM`=0.
- Reset asserted in WAIT or DONE: `DataReq` drops in the same cycle and the access is abandoned.
- Non-memory instruction: 1 cycle in M, never stalls.
- Zero-wait memory (ack in the request cycle): 2 cycles in M, with `StallM`=1 for exactly 1 cycle.
- N-cycle wait: `StallM`=1 for N+1 cycles. The request is held for N+1 cycles.
- `ALUResultM` stays stable throughout a stall, so forwarding remains valid.
- `StallM` depends combinationally on the registered state and the M-stage register only. It never depends on `DataAck`.
- Back-to-back memory ops: DONE returns to IDLE. The next request is issued in the IDLE cycle that follows, with no extra gap.

## Test plan
- Reset mid-WAIT (sw pending, ack withheld): assert `reset` -> `DataReq`=0 and `StallM`=0 immediately, outputs at reset values, no ack consumed.
- sw x=0xDEADBEEF to 0x100 with ack in the same cycle -> `DataReq`=1, `DataWE`=1, `DataAddr`=0x100, `DataBE`=1111, `StallM` pattern 1,0.
- lb from 0x103 with `DataRData`=0x80FF_1234 and ack after 3 wait cycles -> `StallM` high for 4 cycles, `ReadDataM`=0xFFFF_FF80 in DONE.
- lhu from 0x202 with `DataRData`=0xBEEF_0000 -> `ReadDataM`=0x0000_BEEF. sh 0x1234 to 0x202 -> `DataBE`=1100, `DataWData`=0x1234_1234.
- lw from 0x101 -> `DataReq` stays 0, `MisalignM`=1 for 1 cycle, `RegWriteM`=0, `ReadDataM`=0, `StallM`=0.
- add followed by back-to-back sw and lw, zero-wait -> add 1 cycle, each mem op 2 cycles, `ALUResultM` held during stalls, and the second request issued in the cycle after DONE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the five-stage RISC-V pipeline: EX/MEM register, valid/ack data-memory
// access FSM, store byte-lane steering, load alignment/extension and pipeline stall.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [2:0]  ResultSrcE,
  input  logic [1:0]  StoreSrcE,
  input  logic [2:0]  LoadSrcE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        DataAck,
  input  logic [31:0] DataRData,
  output logic        DataReq,
  output logic        DataWE,
  output logic [31:0] DataAddr,
  output logic [3:0]  DataBE,
  output logic [31:0] DataWData,
  output logic        RegWriteM,
  output logic [2:0]  ResultSrcM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        reg_write_q, mem_write_q;
  logic [2:0]  result_src_q, load_src_q;
  logic [1:0]  store_src_q;
  logic [31:0] alu_result_q, write_data_q, pc_plus4_q;
  logic [4:0]  rd_q;
  logic [31:0] rbuf_q, rbuf_d;

  logic        is_load, mem_m, size_word, size_half, aligned, misalign, req, stall;
  logic [1:0]  a;
  logic [31:0] byte_word, half_word, ld_data, wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be;

  assign a = alu_result_q[1:0];

  // Access size comes from the store or load encoding, whichever applies.
  always_comb begin
    is_load = (result_src_q == 3'b001) & ~mem_write_q;
    mem_m   = mem_write_q | (result_src_q == 3'b001);
    if (mem_write_q) begin
      size_word = (store_src_q == 2'b00);
      size_half = (store_src_q == 2'b01);
    end else begin
      size_word = (load_src_q == 3'b000);
      size_half = (load_src_q == 3'b001) | (load_src_q == 3'b010);
    end
    if (size_word)      aligned = (a == 2'b00);
    else if (size_half) aligned = ~a[0];
    else                aligned = 1'b1;
    misalign = mem_m & ~aligned;
  end

  always_comb begin
    req = 1'b0;
    case (state_q)
      StIdle:  req = mem_m & aligned;
      StWait:  req = 1'b1;
      default: req = 1'b0;
    endcase
    stall = ((state_q == StIdle) & req) | (state_q == StWait);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req) state_d = DataAck ? StDone : StWait;
      StWait:  if (DataAck) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (size_word) begin
      be    = 4'b1111;
      wdata = write_data_q;
    end else if (size_half) begin
      be    = 4'b0011 << {a[1], 1'b0};
      wdata = {2{write_data_q[15:0]}};
    end else begin
      be    = 4'b0001 << a;
      wdata = {4{write_data_q[7:0]}};
    end
  end

  always_comb begin
    byte_word = DataRData >> {a, 3'b000};
    half_word = DataRData >> {a[1], 4'b0000};
    ld_byte   = byte_word[7:0];
    ld_half   = half_word[15:0];
    case (load_src_q)
      3'b000:  ld_data = DataRData;
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = {16'h0000, ld_half};
      3'b011:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      default: ld_data = {24'h000000, ld_byte};
    endcase
    rbuf_d = (req & DataAck & is_load) ? ld_data : rbuf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      rbuf_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      store_src_q  <= '0;
      load_src_q   <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      if (!stall) begin
        reg_write_q  <= RegWriteE;
        mem_write_q  <= MemWriteE;
        result_src_q <= ResultSrcE;
        store_src_q  <= StoreSrcE;
        load_src_q   <= LoadSrcE;
        alu_result_q <= ALUResultE;
        write_data_q <= WriteDataE;
        pc_plus4_q   <= PCPlus4E;
        rd_q         <= RdE;
      end
    end
  end

  assign DataReq    = req;
  assign DataWE     = req & mem_write_q;
  assign DataAddr   = {alu_result_q[31:2], 2'b00};
  assign DataBE     = req ? be : 4'b0000;
  assign DataWData  = (req & mem_write_q) ? wdata : 32'h0;
  assign StallM     = stall;
  assign MisalignM  = misalign;
  // A misaligned load must not retire into the register file.
  assign RegWriteM  = reg_write_q & ~(misalign & is_load);
  assign ResultSrcM = result_src_q;
  assign RdM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign PCPlus4M   = pc_plus4_q;
  assign ReadDataM  = misalign ? 32'h0 : rbuf_q;

endmodule
